// File: rtl/aes_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_arb_pkg
// Description : Shared types and constants for the two-port AES request
//               arbiter (FSM encoding, requester ids, default abort window).
// Revision    : 1.0 - initial release
// ============================================================================
package aes_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_BUSY  = 3'd2,
      ST_RESP  = 3'd3
`ifdef AES_ARB_TIMEOUT_EN
      ,ST_ABORT = 3'd4
`endif
   } arbState_t;

   localparam logic c_ID0 = 1'b0;
   localparam logic c_ID1 = 1'b1;

   localparam int c_TIMEOUT_DEFAULT = 64;

endpackage
`default_nettype wire

// File: rtl/aes_req_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin grant; the pointer moves only when the
//               grant is actually accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   input  logic       i_accept,
   output logic [1:0] o_grant
);

   logic r_favor1;

   always_comb begin
      o_grant = 2'b00;
      if (i_req[0] && !(i_req[1] && r_favor1)) begin
         o_grant = 2'b01;
      end else if (i_req[1]) begin
         o_grant = 2'b10;
      end
   end

   // Favour whichever port was not just served.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_favor1 <= 1'b0;
      end else if (i_accept) begin
         r_favor1 <= o_grant[0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/aes_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : aes_req_arbiter
// Description : Shares one AES core between two requesters, one block at a
//               time. Define AES_ARB_TIMEOUT_EN to enable the BUSY abort path.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_req_arbiter
   import aes_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = c_TIMEOUT_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [127:0] req0_chave,
   input  logic [127:0] req0_palavra,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [127:0] req1_chave,
   input  logic [127:0] req1_palavra,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic [127:0] rsp0_cifra,
   output logic         rsp0_err,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [127:0] rsp1_cifra,
   output logic         rsp1_err,
   output logic         aes_start,
   output logic [127:0] aes_chave,
   output logic [127:0] aes_palavra,
   input  logic [127:0] aes_cifra,
   input  logic         aes_done,
   output logic         aes_rst,
   output logic         busy
);

   arbState_t    r_state;
   logic         r_id;
   logic [127:0] r_key;
   logic [127:0] r_pt;
   logic [127:0] r_cifra0;
   logic [127:0] r_cifra1;
   logic         r_rspValid0;
   logic         r_rspValid1;
   logic         r_start;
   logic [1:0]   w_grant;
   logic         w_accept;

   rr_arb2 u_rrArb (
      .clk      (clk),
      .rst      (rst),
      .i_req    ({req1_valid, req0_valid}),
      .i_accept (w_accept),
      .o_grant  (w_grant)
   );

   // Ready is decided in the IDLE cycle itself so the start pulse lands one cycle later.
   assign w_accept   = rst && (r_state == ST_IDLE) && (req0_valid || req1_valid);
   assign req0_ready = w_accept && w_grant[0];
   assign req1_ready = w_accept && w_grant[1];

   assign busy        = (r_state != ST_IDLE);
   assign aes_start   = r_start;
   assign aes_chave   = r_key;
   assign aes_palavra = r_pt;
   assign rsp0_valid  = r_rspValid0;
   assign rsp1_valid  = r_rspValid1;
   assign rsp0_cifra  = r_cifra0;
   assign rsp1_cifra  = r_cifra1;

`ifdef AES_ARB_TIMEOUT_EN
   localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [c_CNT_W-1:0] r_cnt;
   logic               r_err0;
   logic               r_err1;

   assign rsp0_err = r_err0;
   assign rsp1_err = r_err1;
   assign aes_rst  = !rst || (r_state == ST_ABORT);
`else
   assign rsp0_err = 1'b0;
   assign rsp1_err = 1'b0;
   assign aes_rst  = !rst;

   // Without the abort path the window length has no hardware behind it.
   if (TIMEOUT_CYCLES > 0) begin : g_noTimeout
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_id        <= c_ID0;
         r_key       <= '0;
         r_pt        <= '0;
         r_cifra0    <= '0;
         r_cifra1    <= '0;
         r_rspValid0 <= 1'b0;
         r_rspValid1 <= 1'b0;
         r_start     <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
         r_cnt       <= '0;
         r_err0      <= 1'b0;
         r_err1      <= 1'b0;
`endif
      end else begin
         r_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_id    <= w_grant[1];
                  r_key   <= w_grant[1] ? req1_chave   : req0_chave;
                  r_pt    <= w_grant[1] ? req1_palavra : req0_palavra;
                  r_start <= 1'b1;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_state <= ST_BUSY;
`ifdef AES_ARB_TIMEOUT_EN
               r_cnt   <= '0;
`endif
            end
            ST_BUSY: begin
               if (aes_done) begin
                  r_state <= ST_RESP;
                  r_key   <= '0;
                  r_pt    <= '0;
                  if (r_id == c_ID1) begin
                     r_cifra1    <= aes_cifra;
                     r_rspValid1 <= 1'b1;
                  end else begin
                     r_cifra0    <= aes_cifra;
                     r_rspValid0 <= 1'b1;
                  end
               end
`ifdef AES_ARB_TIMEOUT_EN
               else if (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  r_state <= ST_ABORT;
                  r_key   <= '0;
                  r_pt    <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
`ifdef AES_ARB_TIMEOUT_EN
            ST_ABORT: begin
               r_state <= ST_RESP;
               if (r_id == c_ID1) begin
                  r_cifra1    <= '0;
                  r_rspValid1 <= 1'b1;
                  r_err1      <= 1'b1;
               end else begin
                  r_cifra0    <= '0;
                  r_rspValid0 <= 1'b1;
                  r_err0      <= 1'b1;
               end
            end
`endif
            ST_RESP: begin
               if ((r_id == c_ID1) ? rsp1_ready : rsp0_ready) begin
                  r_state     <= ST_IDLE;
                  r_rspValid0 <= 1'b0;
                  r_rspValid1 <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
                  r_err0      <= 1'b0;
                  r_err1      <= 1'b0;
`endif
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 64, maximum cycles BUSY waits for aes_done before abort; used only with AES_ARB_TIMEOUT_EN.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has a block to encrypt.
REQ-005 reqN_ready  output  1  one-cycle accept pulse to requester N.
REQ-006 reqN_chave  input  128  requester N key; sampled on accept.
REQ-007 reqN_palavra  input  128  requester N plaintext; sampled on accept.
REQ-008 rspN_valid  output  1  ciphertext for requester N available.
REQ-009 rspN_ready  input  1  requester N consumes response.
REQ-010 rspN_cifra  output  128  ciphertext for requester N.
REQ-011 rspN_err  output  1  response is an abort (timeout), not valid ciphertext.
REQ-012 aes_start  output  1  start pulse to the shared AES core.
REQ-013 aes_chave  output  128  key to core.
REQ-014 aes_palavra  output  128  plaintext to core.
REQ-015 aes_cifra  input  128  core ciphertext; valid when aes_done=1.
REQ-016 aes_done  input  1  core one-cycle completion pulse.
REQ-017 aes_rst  output  1  active-high reset to core.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states IDLE, ISSUE, BUSY, RESP, plus ABORT when AES_ARB_TIMEOUT_EN is defined.
REQ-020 IDLE: if any reqN_valid, pulse granted reqN_ready, capture its chave/palavra and requester id, go ISSUE next cycle.
REQ-021 Both valid in the same IDLE cycle: grant the requester not granted last (round-robin); after reset, port 0 wins first.
REQ-022 ISSUE: aes_start=1 for exactly one cycle, then BUSY.
REQ-023 aes_chave/aes_palavra hold captured operands from ISSUE until BUSY exits; 0 in IDLE.
REQ-024 BUSY: on aes_done, capture aes_cifra into granted rspN_cifra, go RESP.
REQ-025 RESP: granted rspN_valid held high with stable cifra/err until rspN_ready=1; that cycle go IDLE and drop rspN_valid.
REQ-026 Latency: accept cycle t, aes_start at t+1, rspN_valid at d+1 for aes_done at cycle d.
REQ-027 No new request accepted outside IDLE; reqN_ready never asserted for both ports in one cycle.
REQ-028 aes_done outside BUSY ignored.
REQ-029 Non-granted rspN_valid, rspN_err stay 0; rspN_cifra retains last value.

Reset
REQ-030 rst=0 at a rising edge: state IDLE, round-robin pointer to favour port 0, all outputs 0 except aes_rst.
REQ-031 aes_rst=1 while rst=0, including reset mid-operation; in-flight request dropped with no response.

Configuration
REQ-032 AES_ARB_TIMEOUT_EN defined: BUSY counter counts from 0 and reaches TIMEOUT_CYCLES without aes_done -> ABORT.
REQ-033 ABORT: aes_rst=1 one cycle, then RESP with rspN_err=1, rspN_cifra=0.
REQ-034 aes_done in the timeout cycle: done wins, normal response.
REQ-035 Macro undefined: no counter, no ABORT state, rspN_err tied 0, BUSY waits indefinitely.

Structure
REQ-036 Package aes_arb_pkg holds state encodings, requester-id constants, and default TIMEOUT_CYCLES.
REQ-037 Sub-module rr_arb2: two-input round-robin grant with pointer update on accept.

Verification
REQ-038 Port 0 key 000102..0f, plaintext 00112233..eeff -> rsp0_cifra=69c4e0d86a7b0430d8cdb78070b4c55a, rsp0_err=0.
REQ-039 Both valid at same IDLE cycle after reset -> port 0 served first, port 1 second; repeat -> port 1 first.
REQ-040 rsp0_ready held low 20 cycles -> rsp0_valid and cifra stable; no new accept on either port.
REQ-041 rst=0 during BUSY -> aes_rst=1, busy=0, no rspN_valid; next request completes correctly.
REQ-042 AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, core never done -> aes_rst pulse, rsp err=1, cifra=0; done on cycle 8 -> normal response.
